// File: rtl/mips_cpu_bus_pkg.sv
// Shared types and constants for the mips_cpu_bus memory-side logic.
package mips_cpu_bus_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    GRANT_IF   = 1'b0,
    GRANT_DATA = 1'b1
  } grant_t;

  localparam logic [DATA_W-1:0] RESET_VECTOR = 32'hBFC00000;

endpackage

// File: rtl/mips_cpu_bus_arbiter.sv
// Round-robin arbiter sharing one Avalon-style master port between
// instruction fetch and data access, with a sticky stall-timeout flag.
module mips_cpu_bus_arbiter
  import mips_cpu_bus_pkg::*;
#(
  parameter int unsigned WAIT_TIMEOUT = 1023,
  parameter int unsigned TO_WIDTH     = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [DATA_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_write,
  input  logic [DATA_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [BE_W-1:0]   d_byteenable,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic [DATA_W-1:0] address,
  output logic              write,
  output logic              read,
  input  logic              waitrequest,
  output logic [DATA_W-1:0] writedata,
  output logic [BE_W-1:0]   byteenable,
  input  logic [DATA_W-1:0] readdata,
  output logic              bus_error
);

  arb_state_t            state_q, state_d;
  grant_t                grant_q, grant_d;
  grant_t                last_grant_q, last_grant_d;
  grant_t                win;
  logic [DATA_W-1:0]     address_q, address_d;
  logic [DATA_W-1:0]     writedata_q, writedata_d;
  logic [BE_W-1:0]       byteenable_q, byteenable_d;
  logic                  read_q, read_d;
  logic                  write_q, write_d;
  logic                  if_ack_q, if_ack_d;
  logic                  d_ack_q, d_ack_d;
  logic [DATA_W-1:0]     if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]     d_rdata_q, d_rdata_d;
  logic                  bus_error_q, bus_error_d;
  logic [TO_WIDTH-1:0]   stall_cnt_q, stall_cnt_d;
  logic                  timeout_hit;

  // Contested requests go to whichever port did not win last time.
  always_comb begin
    win = GRANT_IF;
    if (if_req && d_req) begin
      win = (last_grant_q == GRANT_IF) ? GRANT_DATA : GRANT_IF;
    end else if (d_req) begin
      win = GRANT_DATA;
    end
  end

  // This stall cycle is the one that brings the count up to the limit.
  assign timeout_hit = (WAIT_TIMEOUT != 0) &&
                       (stall_cnt_q >= TO_WIDTH'(WAIT_TIMEOUT - 1));

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    address_d    = address_q;
    writedata_d  = writedata_q;
    byteenable_d = byteenable_q;
    read_d       = read_q;
    write_d      = write_q;
    if_ack_d     = 1'b0;
    d_ack_d      = 1'b0;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    bus_error_d  = bus_error_q;
    stall_cnt_d  = stall_cnt_q;

    unique case (state_q)
      IDLE: begin
        read_d  = 1'b0;
        write_d = 1'b0;
        if (if_req || d_req) begin
          grant_d     = win;
          stall_cnt_d = '0;
          state_d     = BUSY;
          if (win == GRANT_IF) begin
            address_d    = if_addr;
            read_d       = 1'b1;
            byteenable_d = '1;
            writedata_d  = '0;
          end else begin
            address_d    = d_addr;
            read_d       = !d_write;
            write_d      = d_write;
            byteenable_d = d_byteenable;
            writedata_d  = d_wdata;
          end
        end
      end

      BUSY: begin
        if (waitrequest) begin
          if (stall_cnt_q < TO_WIDTH'(WAIT_TIMEOUT)) begin
            stall_cnt_d = stall_cnt_q + TO_WIDTH'(1);
          end
          if (timeout_hit) begin
            bus_error_d = 1'b1;
          end
        end else begin
          read_d       = 1'b0;
          write_d      = 1'b0;
          last_grant_d = grant_q;
          state_d      = RESP;
          if (grant_q == GRANT_IF) begin
            if_ack_d   = 1'b1;
            if_rdata_d = readdata;
          end else begin
            d_ack_d = 1'b1;
            if (read_q) begin
              d_rdata_d = readdata;
            end
          end
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= GRANT_IF;
      last_grant_q <= GRANT_DATA;
      address_q    <= '0;
      writedata_q  <= '0;
      byteenable_q <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      if_ack_q     <= 1'b0;
      d_ack_q      <= 1'b0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
      bus_error_q  <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      address_q    <= address_d;
      writedata_q  <= writedata_d;
      byteenable_q <= byteenable_d;
      read_q       <= read_d;
      write_q      <= write_d;
      if_ack_q     <= if_ack_d;
      d_ack_q      <= d_ack_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
      bus_error_q  <= bus_error_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign address    = address_q;
  assign writedata  = writedata_q;
  assign byteenable = byteenable_q;
  assign read       = read_q;
  assign write      = write_q;
  assign if_ack     = if_ack_q;
  assign d_ack      = d_ack_q;
  assign if_rdata   = if_rdata_q;
  assign d_rdata    = d_rdata_q;
  assign bus_error  = bus_error_q;

endmodule

// File: doc/mips_cpu_bus_arbiter.md
Name: mips_cpu_bus_arbiter

Overview:
Shares the single Avalon-style memory master port of mips_cpu_bus between two internal requesters: instruction fetch (read-only) and data access (load/store).
- Sits between the CPU core's fetch/LSU logic and the external memory bus (address/read/write/waitrequest/writedata/byteenable/readdata).
- Serialises requests with round-robin arbitration and holds bus signals stable across waitrequest stalls.
- Returns read data to the winning requester and flags a sticky error if the bus stalls beyond a configured limit.

Parameters:
- WAIT_TIMEOUT, 1023, maximum consecutive waitrequest-high cycles before bus_error sets; 0 disables the check.
- TO_WIDTH, 10, width of the stall counter; must satisfy 2^TO_WIDTH > WAIT_TIMEOUT.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- if_req  input  1  fetch request; held until if_ack.
- if_addr  input  32  fetch byte address.
- if_ack  output  1  one-cycle pulse: fetch complete, if_rdata valid.
- if_rdata  output  32  fetched word.
- d_req  input  1  data request; held until d_ack.
- d_write  input  1  1 = store, 0 = load.
- d_addr  input  32  data byte address.
- d_wdata  input  32  store data.
- d_byteenable  input  4  store/load lane enables.
- d_ack  output  1  one-cycle pulse: data access complete, d_rdata valid for loads.
- d_rdata  output  32  load word.
- address  output  32  bus address.
- write  output  1  bus write strobe.
- read  output  1  bus read strobe.
- waitrequest  input  1  bus stall.
- writedata  output  32  bus write data.
- byteenable  output  4  bus lane enables.
- readdata  input  32  bus read data; valid in the cycle read=1 and waitrequest=0.
- bus_error  output  1  sticky stall-timeout flag.

Behaviour:
- Reset (async, immediate): read=0, write=0, address=0, writedata=0, byteenable=0, if_ack=0, d_ack=0, if_rdata=0, d_rdata=0, bus_error=0, state=IDLE, last_grant=DATA (so fetch wins first).
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - No request pending: read=write=0.
  - Any request pending: choose the winner and register the bus fields; next state is BUSY.
  - Winner when both request: the port not equal to last_grant. Winner when one requests: that port.
  - Fetch win: read=1, byteenable=4'b1111, writedata=0.
  - Data win: read=!d_write, write=d_write, byteenable=d_byteenable, writedata=d_wdata.
- BUSY:
  - All bus outputs stay stable while waitrequest=1.
  - On waitrequest=0: capture readdata into the winner's rdata register (loads and fetches only; store leaves rdata unchanged), drop read/write, update last_grant, go to RESP.
- RESP:
  - Winner's ack=1 for exactly this cycle; then go to IDLE.
  - The requester's req may still be high in RESP. Arbitration resumes in IDLE the following cycle, so a re-asserted req is a new transaction.
- Latency with zero wait states: req seen in cycle N → strobe in N+1 → ack in N+2. Each waitrequest cycle adds one.
- Throughput: at most one transaction per 3 cycles.
- Requests are sampled only in IDLE.
  - Payload changes during BUSY are ignored, because fields are registered.
  - req deasserted during BUSY: the transaction still completes and ack is still pulsed.
- Stall counter:
  - Clears on entry to BUSY and increments each BUSY cycle with waitrequest=1.
  - Reaching WAIT_TIMEOUT sets bus_error; the counter saturates.
  - The transaction keeps waiting; it is not aborted.
  - bus_error clears only on reset.
- read and write are never both 1. if_ack and d_ack are never both 1.
- Addresses are passed unmodified; alignment is the requester's responsibility.

Decomposition:
- Shared package mips_cpu_bus_pkg holds:
  - typedef arb_state_t {IDLE, BUSY, RESP};
  - typedef grant_t {GRANT_IF, GRANT_DATA};
  - constant RESET_VECTOR = 32'hBFC00000, for benches.
- No sub-module; the stall counter is inline.

Test Plan:
- Reset, then if_req=1 with if_addr=32'hBFC00000 and waitrequest=0 → read=1, address=32'hBFC00000, byteenable=4'b1111 in cycle 1; if_ack and if_rdata=readdata in cycle 2.
- if_req and d_req both raised in the same cycle after reset → fetch granted first, then data. With both held continuously, grants alternate IF, DATA, IF.
- Store with d_addr=32'h4, d_wdata=32'hDEADBEEF, d_byteenable=4'b0011, waitrequest high for 3 cycles → write, address, writedata and byteenable stable for 4 cycles; d_ack 1 cycle after waitrequest falls; read stays 0 throughout.
- WAIT_TIMEOUT=4, waitrequest held high → bus_error=1 after the 4th stall cycle and stays set after the transaction completes; reset clears it.
- Reset asserted during BUSY → read/write=0 immediately (no clock edge needed), no ack issued; the next request after reset is fetched normally.
- Load with d_addr=32'h1 and readdata=32'h12345678 while the requester changes d_addr mid-BUSY → address stays 32'h1 and d_rdata=32'h12345678.
